vx_writeback_arb: RTL and testbench

Writeback arbiter sitting directly downstream of the execute stage. It consumes the per-unit commit streams (ALU, LD, ST, CSR, FPU, GPU) and grants one register-writing result per cycle to the register-file writeback port using round-robin priority. It retires non-writing results (stores, `wb=0`) without occupying the port. It also reports the per-cycle count of retired instructions to the CSR unit.

---
 rtl/vx_writeback_arb.sv | 185 ++++++++++++++++++
 tb/tb_vx_writeback_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_writeback_arb.sv
// vx_writeback_arb: round-robin writeback arbiter for the execute-stage
// commit streams (ALU=0, LD=1, ST=2, CSR=3, FPU=4, GPU=5). One register-
// writing result is granted per cycle to the registered writeback port.
// Non-writing results retire freely. The number of eop packets accepted
// each cycle is reported, registered, to the CSR unit.
// Optional feature macro: VX_WB_BACKPRESSURE_EN adds the wb_ready input and
// turns the output register into a 2-entry skid buffer.
module vx_writeback_arb #(
  parameter int NUM_SRCS    = 6,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SRCS-1:0]               cmt_valid,
  output logic [NUM_SRCS-1:0]               cmt_ready,
  input  logic [NUM_SRCS*NW_BITS-1:0]       cmt_wid,
  input  logic [NUM_SRCS*NUM_THREADS-1:0]   cmt_tmask,
  input  logic [NUM_SRCS*32-1:0]            cmt_pc,
  input  logic [NUM_SRCS*NR_BITS-1:0]       cmt_rd,
  input  logic [NUM_SRCS-1:0]               cmt_wb,
  input  logic [NUM_SRCS-1:0]               cmt_eop,
  input  logic [NUM_SRCS*NUM_THREADS*32-1:0] cmt_data,
`ifdef VX_WB_BACKPRESSURE_EN
  input  logic                              wb_ready,
`endif
  output logic                              wb_valid,
  output logic [NW_BITS-1:0]                wb_wid,
  output logic [NUM_THREADS-1:0]            wb_tmask,
  output logic [31:0]                       wb_pc,
  output logic [NR_BITS-1:0]                wb_rd,
  output logic [NUM_THREADS*32-1:0]         wb_data,
  output logic                              wb_eop,
  output logic                              cmt_csr_valid,
  output logic [$clog2(NUM_SRCS+1)-1:0]     cmt_csr_size
);

  // Handshake: a source packet transfers on a rising edge where
  // cmt_valid[i] & cmt_ready[i]; the source holds its fields stable while
  // valid & !ready. On the writeback side (backpressure build) an entry
  // leaves on an edge where wb_valid & wb_ready.

  localparam int PW = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int CW = $clog2(NUM_SRCS + 1);
  localparam int DW = NUM_THREADS * 32;

  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [NR_BITS-1:0]     rd;
    logic [DW-1:0]          data;
    logic                   eop;
  } entry_t;

  logic [PW-1:0] last;
  logic [PW-1:0] grant_idx;
  logic          grant_found;
  logic          slot_accept;
  logic          grant_fire;
  entry_t        sel;
  logic [CW-1:0] eop_cnt;

  // Round-robin search starting one past the last granted writer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_SRCS; k++) begin
      if (!grant_found && cmt_valid[(int'(last) + k) % NUM_SRCS]
          && cmt_wb[(int'(last) + k) % NUM_SRCS]) begin
        grant_found = 1'b1;
        grant_idx   = PW'((int'(last) + k) % NUM_SRCS);
      end
    end
  end

  // Mux the granted source's fields into an output entry.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      if (i == int'(grant_idx)) begin
        sel.wid   = cmt_wid[i*NW_BITS +: NW_BITS];
        sel.tmask = cmt_tmask[i*NUM_THREADS +: NUM_THREADS];
        sel.pc    = cmt_pc[i*32 +: 32];
        sel.rd    = cmt_rd[i*NR_BITS +: NR_BITS];
        sel.data  = cmt_data[i*DW +: DW];
        sel.eop   = cmt_eop[i];
      end
    end
  end

  assign grant_fire = !reset && grant_found && slot_accept;

  // Ready per source and count of eop packets accepted this cycle.
  always_comb begin
    cmt_ready = '0;
    eop_cnt   = '0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      cmt_ready[i] = !reset && cmt_valid[i]
                     && (!cmt_wb[i] || (grant_fire && (i == int'(grant_idx))));
      if (cmt_ready[i] && cmt_eop[i])
        eop_cnt = eop_cnt + CW'(1);
    end
  end

  // Pointer advances only when a writer grant is actually accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           last <= '0;
    else if (grant_fire) last <= grant_idx;
  end

  // Registered retire count for the CSR unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmt_csr_valid <= 1'b0;
      cmt_csr_size  <= '0;
    end else begin
      cmt_csr_valid <= (eop_cnt != '0);
      cmt_csr_size  <= eop_cnt;
    end
  end

  entry_t head;

`ifdef VX_WB_BACKPRESSURE_EN
  entry_t     ent1;
  logic [1:0] cnt;
  logic       pop;

  // Accept a writer unless both entries are full and nothing drains.
  assign slot_accept = (cnt != 2'd2) || wb_ready;
  assign pop         = (cnt != 2'd0) && wb_ready;
  assign wb_valid    = (cnt != 2'd0);

  // Two-entry skid buffer; head is the presented writeback entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= 2'd0;
      head <= '0;
      ent1 <= '0;
    end else begin
      if (pop && grant_fire) begin
        if (cnt == 2'd1) begin
          head <= sel;
        end else begin
          head <= ent1;
          ent1 <= sel;
        end
      end else if (pop) begin
        head <= ent1;
        cnt  <= cnt - 2'd1;
      end else if (grant_fire) begin
        if (cnt == 2'd0) head <= sel;
        else             ent1 <= sel;
        cnt <= cnt + 2'd1;
      end
    end
  end
`else
  logic head_v;

  assign slot_accept = 1'b1;
  assign wb_valid    = head_v;

  // Single output register, loaded on every accepted writer grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_v <= 1'b0;
      head   <= '0;
    end else begin
      head_v <= grant_fire;
      if (grant_fire) head <= sel;
    end
  end
`endif

  assign wb_wid   = head.wid;
  assign wb_tmask = head.tmask;
  assign wb_pc    = head.pc;
  assign wb_rd    = head.rd;
  assign wb_data  = head.data;
  assign wb_eop   = head.eop;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Directed scoreboard bench for vx_writeback_arb. Expected writeback entries
// and retire counts are queued as stimulus is issued; a negedge monitor pops
// and compares whenever the DUT presents an output.
module tb_vx_writeback_arb;

  localparam int NS  = 6;
  localparam int WBW = 2 + 4 + 32 + 5 + 128 + 1;

  logic          clk;
  logic          reset;
  logic [NS-1:0] cmt_valid;
  logic [NS-1:0] cmt_ready;
  logic [NS*2-1:0]   cmt_wid;
  logic [NS*4-1:0]   cmt_tmask;
  logic [NS*32-1:0]  cmt_pc;
  logic [NS*5-1:0]   cmt_rd;
  logic [NS-1:0]     cmt_wb;
  logic [NS-1:0]     cmt_eop;
  logic [NS*128-1:0] cmt_data;
  logic          wb_ready;
  logic          wb_valid;
  logic [1:0]    wb_wid;
  logic [3:0]    wb_tmask;
  logic [31:0]   wb_pc;
  logic [4:0]    wb_rd;
  logic [127:0]  wb_data;
  logic          wb_eop;
  logic          cmt_csr_valid;
  logic [2:0]    cmt_csr_size;

  logic [WBW-1:0] exp_q[$];
  logic [2:0]     csr_q[$];
  int total;
  int bad;
  logic mon_en;

  vx_writeback_arb dut (
    .clk(clk), .reset(reset),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
    .cmt_wid(cmt_wid), .cmt_tmask(cmt_tmask), .cmt_pc(cmt_pc),
    .cmt_rd(cmt_rd), .cmt_wb(cmt_wb), .cmt_eop(cmt_eop), .cmt_data(cmt_data),
`ifdef VX_WB_BACKPRESSURE_EN
    .wb_ready(wb_ready),
`endif
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_tmask(wb_tmask), .wb_pc(wb_pc),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
    .cmt_csr_valid(cmt_csr_valid), .cmt_csr_size(cmt_csr_size)
  );

  // Clock and reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    cmt_valid = '0; cmt_wb = '0; cmt_eop = '0;
    cmt_wid = '0; cmt_tmask = '0; cmt_pc = '0; cmt_rd = '0; cmt_data = '0;
  endtask

  task automatic set_src(input int i, input logic wb, input logic eop,
                         input logic [4:0] rd, input logic [31:0] d,
                         input logic [1:0] wid, input logic [3:0] tm,
                         input logic [31:0] pc);
    cmt_valid[i] = 1'b1;
    cmt_wb[i]    = wb;
    cmt_eop[i]   = eop;
    cmt_rd[i*5 +: 5]       = rd;
    cmt_data[i*128 +: 128] = {4{d}};
    cmt_wid[i*2 +: 2]      = wid;
    cmt_tmask[i*4 +: 4]    = tm;
    cmt_pc[i*32 +: 32]     = pc;
  endtask

  task automatic drop_src(input int i);
    cmt_valid[i] = 1'b0;
  endtask

  task automatic push_wb(input logic [1:0] wid, input logic [3:0] tm,
                         input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] d, input logic eop);
    exp_q.push_back({wid, tm, pc, rd, {4{d}}, eop});
  endtask

  // Monitor: compare every presented writeback and retire count.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (wb_valid && wb_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wb_unexpected got_rd=%0d", wb_rd);
        end else begin
          logic [WBW-1:0] e;
          e = exp_q.pop_front();
          if ({wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop} !== e) begin
            bad++;
            $display("FAIL wb_pkt got=%h exp=%h",
                     {wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop}, e);
          end
        end
      end
      if (cmt_csr_valid) begin
        total++;
        if (csr_q.size() == 0) begin
          bad++;
          $display("FAIL csr_unexpected got=%0d", cmt_csr_size);
        end else begin
          logic [2:0] c;
          c = csr_q.pop_front();
          if (cmt_csr_size !== c) begin
            bad++;
            $display("FAIL csr_size got=%0d exp=%0d", cmt_csr_size, c);
          end
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; mon_en = 1'b0;
    wb_ready = 1'b1;
    clear_all();
    reset = 1'b1;
    set_src(0, 1'b1, 1'b1, 5'd7, 32'h77, 2'd1, 4'hf, 32'h100);
    step(); step();
    // Reset state.
    check("rst_ready", 32'(cmt_ready), 32'h0);
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_wb_rd", 32'(wb_rd), 32'h0);
    check("rst_csr_size", 32'(cmt_csr_size), 32'h0);
    check("rst_csr_valid", 32'(cmt_csr_valid), 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmt_ready), 32'h01);
    step();
    check("mid_wb_valid", 32'(wb_valid), 32'h1);
    // Asynchronous reset in the middle of a transfer.
    reset = 1'b1;
    #1;
    check("async_wb_valid", 32'(wb_valid), 32'h0);
    check("async_csr_size", 32'(cmt_csr_size), 32'h0);
    check("async_ready", 32'(cmt_ready), 32'h0);
    clear_all();
    step(); step();
    reset = 1'b0;
    step();
    mon_en = 1'b1;

    // ALU alone.
    set_src(0, 1'b1, 1'b1, 5'd5, 32'h11, 2'd2, 4'hf, 32'h200);
    #1;
    check("alu_ready", 32'(cmt_ready), 32'h01);
    push_wb(2'd2, 4'hf, 32'h200, 5'd5, 32'h11, 1'b1);
    csr_q.push_back(3'd1);
    step();
    clear_all();
    step();

    // ALU and CSR contending: alternate CSR, ALU, ...
    set_src(0, 1'b1, 1'b1, 5'd1, 32'hA0, 2'd0, 4'h3, 32'h300);
    set_src(3, 1'b1, 1'b1, 5'd3, 32'hC3, 2'd3, 4'h5, 32'h400);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c % 2 == 0) begin
        check("alt_ready_csr", 32'(cmt_ready), 32'h08);
        push_wb(2'd3, 4'h5, 32'h400, 5'd3, 32'hC3, 1'b1);
      end else begin
        check("alt_ready_alu", 32'(cmt_ready), 32'h01);
        push_wb(2'd0, 4'h3, 32'h300, 5'd1, 32'hA0, 1'b1);
      end
      csr_q.push_back(3'd1);
      step();
    end
    clear_all();
    step();

    // ST (no wb) + LD writer + GPU partial non-writer in one cycle.
    set_src(2, 1'b0, 1'b1, 5'd0, 32'h22, 2'd0, 4'h1, 32'h500);
    set_src(1, 1'b1, 1'b1, 5'd9, 32'h99, 2'd1, 4'h6, 32'h504);
    set_src(5, 1'b0, 1'b0, 5'd0, 32'h55, 2'd2, 4'h8, 32'h508);
    #1;
    check("mix_ready", 32'(cmt_ready), 32'h26);
    push_wb(2'd1, 4'h6, 32'h504, 5'd9, 32'h99, 1'b1);
    csr_q.push_back(3'd2);
    step();
    clear_all();
    step();

    // FPU alone moves the pointer to 4; then 5 and 0 wrap.
    set_src(4, 1'b1, 1'b1, 5'd4, 32'h44, 2'd0, 4'hf, 32'h600);
    push_wb(2'd0, 4'hf, 32'h600, 5'd4, 32'h44, 1'b1);
    csr_q.push_back(3'd1);
    step();
    clear_all();
    set_src(5, 1'b1, 1'b1, 5'd15, 32'h5A, 2'd1, 4'h9, 32'h700);
    set_src(0, 1'b1, 1'b1, 5'd16, 32'h0B, 2'd2, 4'ha, 32'h704);
    #1;
    check("wrap_ready_5", 32'(cmt_ready), 32'h20);
    push_wb(2'd1, 4'h9, 32'h700, 5'd15, 32'h5A, 1'b1);
    csr_q.push_back(3'd1);
    step();
    drop_src(5);
    #1;
    check("wrap_ready_0", 32'(cmt_ready), 32'h01);
    push_wb(2'd2, 4'ha, 32'h704, 5'd16, 32'h0B, 1'b1);
    csr_q.push_back(3'd1);
    step();
    clear_all();
    step();

    // Partial writer packet: forwarded with eop=0, not counted.
    set_src(3, 1'b1, 1'b0, 5'd20, 32'hDD, 2'd3, 4'h2, 32'h800);
    push_wb(2'd3, 4'h2, 32'h800, 5'd20, 32'hDD, 1'b0);
    step();
    clear_all();
    step();

`ifdef VX_WB_BACKPRESSURE_EN
    // Stalled register file: two packets absorbed, third held.
    wb_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      set_src(0, 1'b1, 1'b1, 5'(p + 1), 32'hB0 + 32'(p), 2'd0, 4'hf, 32'h900 + 32'(4*p));
      #1;
      check("bp_ready", 32'(cmt_ready), (p < 2) ? 32'h01 : 32'h00);
      if (p < 2) begin
        push_wb(2'd0, 4'hf, 32'h900 + 32'(4*p), 5'(p + 1), 32'hB0 + 32'(p), 1'b1);
        csr_q.push_back(3'd1);
      end
      step();
    end
    check("bp_hold_valid", 32'(wb_valid), 32'h1);
    check("bp_hold_rd", 32'(wb_rd), 32'h1);
    wb_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(cmt_ready), 32'h01);
    push_wb(2'd0, 4'hf, 32'h908, 5'd3, 32'hB2, 1'b1);
    csr_q.push_back(3'd1);
    step();
    clear_all();
`endif

    for (int w = 0; w < 5; w++) step();
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    check("csr_q_empty", 32'(csr_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
